// File: rtl/adc_serial_responder_pkg.sv
// Shared types and constants for the serial ADC responder: source modes,
// LFSR definition, default frame geometry and the frame-state enumeration.
package adc_serial_responder_pkg;

  localparam int unsigned DEF_LEAD_ZEROS = 4;
  localparam int unsigned DEF_DATA_W     = 12;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } frame_state_e;

  // x^12 + x^6 + x^4 + x + 1 -> taps on bits 11, 5, 3, 0
  localparam int unsigned      LFSR_W    = 12;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 12'h829;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 12'h001;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/adc_serial_responder_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin followed by a one-flop
// edge detector producing single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              level;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = din;
    level     = sync_q[STAGES-1];
    prev_d    = level;
    rise      = level & ~prev_q;
    fall      = ~level & prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/adc_serial_responder.sv
// Emulates a 12-bit serial ADC: answers CS/CLK bursts from the acquisition
// controller with {leading zeros, sample} MSB first on sdoAdc.
module adc_serial_responder
  import adc_serial_responder_pkg::*;
#(
  parameter int unsigned LEAD_ZEROS  = DEF_LEAD_ZEROS,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              csAdc,
  input  logic              clkAdc,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] patWord,
  output logic              sdoAdc,
  output logic              sdoEn,
  output logic              busy,
  output logic [15:0]       frameCount,
  output logic              abortFlag
);

  localparam int unsigned N  = LEAD_ZEROS + DATA_W;
  localparam int unsigned CW = $clog2(N + 1);

  logic cs_rise, cs_fall, clk_fall, unused_clk_rise;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .rst_n (resetN),
    .din   (csAdc),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .rst_n (resetN),
    .din   (clkAdc),
    .rise  (unused_clk_rise),
    .fall  (clk_fall)
  );

  frame_state_e      state_q, state_d;
  logic [N-1:0]      shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              sdo_q, sdo_d;
  logic              sdo_en_q, sdo_en_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic              phase_q, phase_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  mode_e             fmode_q, fmode_d;
  logic [DATA_W-1:0] sample;
  logic              last_fall;

  assign last_fall = clk_fall && (bit_cnt_q == CW'(N));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
               else if (last_fall) state_d = DONE;
      DONE:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (mode_e'(mode))
      MODE_RAMP: sample = ramp_q;
      MODE_ALT:  sample = phase_q ? ~patWord : patWord;
      MODE_LFSR: sample = DATA_W'(lfsr_q);
      default:   sample = patWord;
    endcase
  end

  // Clock edges are only acted on in SHIFT, so a clkAdc fall coincident
  // with the CS fall (seen in IDLE) is dropped without extra logic.
  always_comb begin
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    sdo_d       = sdo_q;
    sdo_en_d    = sdo_en_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    abort_d     = abort_q;
    ramp_d      = ramp_q;
    phase_d     = phase_q;
    lfsr_d      = lfsr_q;
    fmode_d     = fmode_q;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shreg_d   = N'(sample);
          sdo_d     = shreg_d[N-1];
          bit_cnt_d = CW'(1);
          busy_d    = 1'b1;
          sdo_en_d  = 1'b1;
          fmode_d   = mode_e'(mode);
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort_d  = 1'b1;
          busy_d   = 1'b0;
          sdo_en_d = 1'b0;
          sdo_d    = 1'b0;
        end else if (last_fall) begin
          sdo_en_d    = 1'b0;
          sdo_d       = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          unique case (fmode_q)
            MODE_RAMP: ramp_d  = ramp_q + 1'b1;
            MODE_ALT:  phase_d = ~phase_q;
            MODE_LFSR: lfsr_d  = lfsr_next(lfsr_q);
            default:   ;
          endcase
        end else if (clk_fall) begin
          shreg_d   = shreg_q << 1;
          sdo_d     = shreg_d[N-1];
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      sdo_q       <= 1'b0;
      sdo_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      abort_q     <= 1'b0;
      ramp_q      <= '0;
      phase_q     <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      fmode_q     <= MODE_FIXED;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      sdo_q       <= sdo_d;
      sdo_en_q    <= sdo_en_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      abort_q     <= abort_d;
      ramp_q      <= ramp_d;
      phase_q     <= phase_d;
      lfsr_q      <= lfsr_d;
      fmode_q     <= fmode_d;
    end
  end

  assign sdoAdc     = sdo_q;
  assign sdoEn      = sdo_en_q;
  assign busy       = busy_q;
  assign frameCount = frame_cnt_q;
  assign abortFlag  = abort_q;

endmodule
